pri_cpi_timing_gen: RTL and testbench
=====================================

// Module: pri_cpi_timing_gen
// PURPOSE
//  Parametrised PRI/CPI radar timing generator for the HSC signal chain.
//  Produces PRI and CPI strobes, pulse-active windows, first-PRI flag and ping-pong SRIO memory select.
//  Supports continuous and single-CPI modes, shadow-latched configuration and graceful stop.
//  Sits between the control registers and the ADC/DDC/SRIO capture path.
// PARAMETERS
//  CNT_W   16  width of PRI length, CPI length, pulse width and all counters
//  WT_W    3   width of waveform-type field (2**WT_W waveform types)
//  MIN_PRI 4   minimum legal PRI length in clocks; smaller requests are clamped up to this
// PORTS
//  clk              in   1      system clock; all logic on rising edge
//  rstn             in   1      synchronous reset, active-low
//  i_Enable         in   1      level; 1 = run, 0 = stop at next CPI boundary
//  i_Single_CPI     in   1      1 = run exactly one CPI per enable rise, then idle
//  i_PRI_Width      in   CNT_W  clocks per PRI
//  i_CPI_Width      in   CNT_W  PRIs per CPI
//  i_Pulse_Width    in   CNT_W  clocks of o_PRI_Internal high per PRI
//  i_Waveform_Type  in   WT_W   waveform selector applied from the next CPI
//  o_PRI_p          out  1      1-clock strobe, first clock of every PRI
//  o_CPI_p          out  1      1-clock strobe, first clock of every CPI
//  o_PRI_Internal   out  1      high for first pulse-width clocks of every PRI
//  o_CPI_Internal   out  1      high for every clock inside an active CPI
//  o_First_PRI      out  1      high for every clock of PRI index 0 of a CPI
//  o_SRIO_Mem_Sel   out  1      ping-pong buffer select; toggles at each CPI start
//  o_Waveform_Type  out  WT_W   waveform type latched for the current CPI
//  o_PRI_Idx        out  CNT_W  PRI index within current CPI, 0..CPI_W-1
//  o_CPI_Cnt        out  CNT_W  completed-CPI counter, wraps at 2**CNT_W
//  o_Busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): state=IDLE, counters=0, all outputs 0, including o_SRIO_Mem_Sel.
//  Reset mid-CPI: immediate abort, no trailing strobes.
//  States:
//   IDLE -> RUN when i_Enable=1 sampled.
//   RUN -> STOP when i_Enable=0 sampled; current CPI completes.
//   RUN/STOP -> IDLE at the last clock of the last PRI of a CPI if stopping, or if i_Single_CPI=1.
//   STOP -> RUN if i_Enable returns to 1 before the boundary.
//   Single-CPI: after returning to IDLE, a new CPI requires i_Enable to fall then rise.
//  Shadow config: PRI_W, CPI_W, PULSE_W and waveform type are latched on the clock before each CPI's first clock.
//  Input changes mid-CPI have no effect until the next CPI.
//  Clamping:
//   PRI_W = max(i_PRI_Width, MIN_PRI).
//   CPI_W = max(i_CPI_Width, 1).
//   PULSE_W = min(i_Pulse_Width, PRI_W-1); 0 allowed, giving o_PRI_Internal never high.
//  Latency: the first CPI clock (o_CPI_p=o_PRI_p=1) is 2 clocks after the edge sampling i_Enable=1 in IDLE.
//  Counters:
//   pri_cnt runs 0..PRI_W-1. At wrap, o_PRI_Idx increments.
//   At o_PRI_Idx=CPI_W-1 with pri_cnt wrap, a CPI ends:
//    - o_CPI_Cnt += 1;
//    - the next CPI starts on the immediately following clock (no gap) if still RUN.
//  Outputs in the clock where pri_cnt == k:
//   o_PRI_p = (k==0).
//   o_PRI_Internal = (k < PULSE_W).
//   o_CPI_p = (k==0 && o_PRI_Idx==0).
//   o_First_PRI = (o_PRI_Idx==0).
//  o_CPI_Internal: 1 from the first CPI clock to the last CPI clock inclusive; 0 in IDLE.
//  o_SRIO_Mem_Sel toggles in the same clock o_CPI_p asserts; it holds its value in IDLE.
//  o_Waveform_Type updates in the same clock as o_CPI_p.
//  o_PRI_Idx and o_CPI_Cnt hold in IDLE; o_PRI_Idx clears to 0 at each CPI start.
//  All outputs registered; no combinational input-to-output paths.
// TESTING
//  PRI=130, CPI=5, pulse=4, continuous:
//   - o_PRI_p every 130 clk and o_CPI_p every 650 clk;
//   - o_PRI_Internal high 4 clk per PRI;
//   - o_Mem_Sel toggles 0->1->0 across CPIs.
//  Single-CPI, PRI=10, CPI=3:
//   - exactly 3 o_PRI_p and 1 o_CPI_p, then o_Busy=0 and o_CPI_Cnt=1;
//   - enable held high gives no restart.
//  Drop i_Enable at PRI idx 1 of a CPI=5 run:
//   - CPI finishes all 5 PRIs;
//   - o_CPI_Internal falls after the last clock; IDLE.
//  Change i_PRI_Width 130->20 and i_Waveform_Type 2->5 mid-CPI:
//   - current CPI keeps 130 and 2;
//   - next o_CPI_p brings 20-clk PRIs and o_Waveform_Type=5.
//  Clamp cases:
//   - PRI=1 -> period 4 (MIN_PRI);
//   - CPI=0 -> every PRI strobes o_CPI_p;
//   - pulse=200 with PRI=20 -> PRI_Internal high 19 clk.
//  Assert rstn=0 for 1 clk at PRI idx 2:
//   - all outputs 0 next clk including Mem_Sel;
//   - restart gives first o_CPI_p 2 clk after enable sampled.

Source files
------------

// File: rtl/pri_cpi_timing_gen.sv
// PRI/CPI radar timing generator: PRI/CPI strobes, pulse windows and ping-pong buffer select,
// driven from per-CPI shadow configuration with graceful stop and single-CPI operation.
module pri_cpi_timing_gen #(
    parameter int CNT_W   = 16,
    parameter int WT_W    = 3,
    parameter int MIN_PRI = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_Enable,
    input  logic             i_Single_CPI,
    input  logic [CNT_W-1:0] i_PRI_Width,
    input  logic [CNT_W-1:0] i_CPI_Width,
    input  logic [CNT_W-1:0] i_Pulse_Width,
    input  logic [WT_W-1:0]  i_Waveform_Type,
    output logic             o_PRI_p,
    output logic             o_CPI_p,
    output logic             o_PRI_Internal,
    output logic             o_CPI_Internal,
    output logic             o_First_PRI,
    output logic             o_SRIO_Mem_Sel,
    output logic [WT_W-1:0]  o_Waveform_Type,
    output logic [CNT_W-1:0] o_PRI_Idx,
    output logic [CNT_W-1:0] o_CPI_Cnt,
    output logic             o_Busy
);

    typedef enum logic [2:0] {IDLE, ARM, PRIME, RUN, STOP} state_e;

    localparam logic [CNT_W-1:0] MinPriW = CNT_W'(MIN_PRI);
    localparam logic [CNT_W-1:0] OneW    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pri_cnt_q, pri_cnt_d, pri_idx_q, pri_idx_d, cpi_cnt_q, cpi_cnt_d;
    logic [CNT_W-1:0] pri_w_q, pri_w_d, cpi_w_q, cpi_w_d, pulse_w_q, pulse_w_d;
    logic [WT_W-1:0]  wt_q, wt_d;
    logic             mem_sel_q, mem_sel_d, need_low_q, need_low_d;
    logic             pri_p_q, pri_p_d, cpi_p_q, cpi_p_d, pri_int_q, pri_int_d;
    logic             cpi_int_q, cpi_int_d, first_pri_q, first_pri_d, busy_q, busy_d;

    logic [CNT_W-1:0] pri_w_in, cpi_w_in, pulse_w_in;
    logic             in_cpi, end_pri, end_cpi, start_cpi;

    always_comb begin
        pri_w_in   = (i_PRI_Width < MinPriW) ? MinPriW : i_PRI_Width;
        cpi_w_in   = (i_CPI_Width == '0) ? OneW : i_CPI_Width;
        pulse_w_in = (i_Pulse_Width > pri_w_in - OneW) ? pri_w_in - OneW : i_Pulse_Width;
    end

    // A new CPI follows the last clock of the previous one without a gap unless stopping.
    always_comb begin
        in_cpi    = (state_q == RUN) || (state_q == STOP);
        end_pri   = in_cpi && (pri_cnt_q == pri_w_q - OneW);
        end_cpi   = end_pri && (pri_idx_q == cpi_w_q - OneW);
        start_cpi = (state_q == PRIME) || (end_cpi && i_Enable && !i_Single_CPI);
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_Enable && !need_low_q) state_d = ARM;
            ARM:       state_d = PRIME;
            PRIME:     state_d = i_Enable ? RUN : STOP;
            RUN, STOP: begin
                if (end_cpi && (!i_Enable || i_Single_CPI)) state_d = IDLE;
                else                                         state_d = i_Enable ? RUN : STOP;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pri_cnt_d   = pri_cnt_q;
        pri_idx_d   = pri_idx_q;
        cpi_cnt_d   = end_cpi ? cpi_cnt_q + OneW : cpi_cnt_q;
        pri_w_d     = pri_w_q;
        cpi_w_d     = cpi_w_q;
        pulse_w_d   = pulse_w_q;
        wt_d        = wt_q;
        mem_sel_d   = mem_sel_q;
        need_low_d  = need_low_q;
        pri_p_d     = 1'b0;
        cpi_p_d     = 1'b0;
        pri_int_d   = 1'b0;
        cpi_int_d   = 1'b0;
        first_pri_d = 1'b0;
        busy_d      = (state_d != IDLE);
        // Single-CPI completion blocks restart until the enable has been seen low.
        if (!i_Enable)                    need_low_d = 1'b0;
        else if (end_cpi && i_Single_CPI) need_low_d = 1'b1;
        if (start_cpi) begin
            pri_w_d     = pri_w_in;
            cpi_w_d     = cpi_w_in;
            pulse_w_d   = pulse_w_in;
            wt_d        = i_Waveform_Type;
            mem_sel_d   = ~mem_sel_q;
            pri_cnt_d   = '0;
            pri_idx_d   = '0;
            pri_p_d     = 1'b1;
            cpi_p_d     = 1'b1;
            pri_int_d   = (pulse_w_in != '0);
            cpi_int_d   = 1'b1;
            first_pri_d = 1'b1;
        end else if (in_cpi && !end_cpi) begin
            cpi_int_d = 1'b1;
            if (end_pri) begin
                pri_cnt_d = '0;
                pri_idx_d = pri_idx_q + OneW;
                pri_p_d   = 1'b1;
                pri_int_d = (pulse_w_q != '0);
            end else begin
                pri_cnt_d   = pri_cnt_q + OneW;
                pri_int_d   = (pri_cnt_q + OneW) < pulse_w_q;
                first_pri_d = (pri_idx_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pri_cnt_q   <= '0;
            pri_idx_q   <= '0;
            cpi_cnt_q   <= '0;
            pri_w_q     <= '0;
            cpi_w_q     <= '0;
            pulse_w_q   <= '0;
            wt_q        <= '0;
            mem_sel_q   <= 1'b0;
            need_low_q  <= 1'b0;
            pri_p_q     <= 1'b0;
            cpi_p_q     <= 1'b0;
            pri_int_q   <= 1'b0;
            cpi_int_q   <= 1'b0;
            first_pri_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pri_cnt_q   <= pri_cnt_d;
            pri_idx_q   <= pri_idx_d;
            cpi_cnt_q   <= cpi_cnt_d;
            pri_w_q     <= pri_w_d;
            cpi_w_q     <= cpi_w_d;
            pulse_w_q   <= pulse_w_d;
            wt_q        <= wt_d;
            mem_sel_q   <= mem_sel_d;
            need_low_q  <= need_low_d;
            pri_p_q     <= pri_p_d;
            cpi_p_q     <= cpi_p_d;
            pri_int_q   <= pri_int_d;
            cpi_int_q   <= cpi_int_d;
            first_pri_q <= first_pri_d;
            busy_q      <= busy_d;
        end
    end

    assign o_PRI_p         = pri_p_q;
    assign o_CPI_p         = cpi_p_q;
    assign o_PRI_Internal  = pri_int_q;
    assign o_CPI_Internal  = cpi_int_q;
    assign o_First_PRI     = first_pri_q;
    assign o_SRIO_Mem_Sel  = mem_sel_q;
    assign o_Waveform_Type = wt_q;
    assign o_PRI_Idx       = pri_idx_q;
    assign o_CPI_Cnt       = cpi_cnt_q;
    assign o_Busy          = busy_q;

endmodule

// File: tb/tb_pri_cpi_timing_gen.sv
// Self-checking bench for pri_cpi_timing_gen: directed and randomized steps compared each
// clock against a reference model that derives outputs from the time offset inside the CPI.
module tb_pri_cpi_timing_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        single;
    logic [15:0] priWidth, cpiWidth, pulseWidth;
    logic [2:0]  wtype;

    logic        oPriP, oCpiP, oPriInt, oCpiInt, oFirst, oMem, oBusy;
    logic [2:0]  oWt;
    logic [15:0] oIdx, oCnt;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: time offset inside the active CPI plus the latched configuration.
    bit mActive   = 1'b0;
    int mT        = 0;
    int mArm      = 0;
    bit mNeedLow  = 1'b0;
    int mPriW     = 4;
    int mCpiW     = 1;
    int mPulseW   = 0;
    int mWt       = 0;
    bit mMem      = 1'b0;
    int mCnt      = 0;

    int obsPriP, obsCpiP, obsPriInt;

    pri_cpi_timing_gen #(.CNT_W(16), .WT_W(3), .MIN_PRI(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_Enable        (en),
        .i_Single_CPI    (single),
        .i_PRI_Width     (priWidth),
        .i_CPI_Width     (cpiWidth),
        .i_Pulse_Width   (pulseWidth),
        .i_Waveform_Type (wtype),
        .o_PRI_p         (oPriP),
        .o_CPI_p         (oCpiP),
        .o_PRI_Internal  (oPriInt),
        .o_CPI_Internal  (oCpiInt),
        .o_First_PRI     (oFirst),
        .o_SRIO_Mem_Sel  (oMem),
        .o_Waveform_Type (oWt),
        .o_PRI_Idx       (oIdx),
        .o_CPI_Cnt       (oCnt),
        .o_Busy          (oBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStartCpi();
        mPriW   = (int'(priWidth) < 4) ? 4 : int'(priWidth);
        mCpiW   = (cpiWidth == 16'd0) ? 1 : int'(cpiWidth);
        mPulseW = (int'(pulseWidth) > mPriW - 1) ? mPriW - 1 : int'(pulseWidth);
        mWt     = int'(wtype);
        mMem    = !mMem;
        mT      = 0;
        mActive = 1'b1;
    endtask

    // Advance the model by one rising edge using the inputs as sampled at that edge.
    task automatic modelStep();
        if (!rstn) begin
            mActive  = 1'b0;
            mArm     = 0;
            mNeedLow = 1'b0;
            mWt      = 0;
            mMem     = 1'b0;
            mCnt     = 0;
            return;
        end
        if (mActive) begin
            if (mT == mPriW * mCpiW - 1) begin
                mCnt = (mCnt + 1) % 65536;
                if (!en || single) begin
                    mActive = 1'b0;
                    if (single && en) mNeedLow = 1'b1;
                end else begin
                    modelStartCpi();
                end
            end else begin
                mT++;
            end
        end else if (mArm > 0) begin
            mArm--;
            if (mArm == 0) modelStartCpi();
        end else if (en && !mNeedLow) begin
            mArm = 2;
        end
        if (!en) mNeedLow = 1'b0;
    endtask

    task automatic compareAll();
        int pc;
        int ix;
        pc = mActive ? mT % mPriW : 0;
        ix = mActive ? mT / mPriW : 0;
        checkOutput("o_PRI_p",         32'(oPriP),   32'(mActive && pc == 0));
        checkOutput("o_CPI_p",         32'(oCpiP),   32'(mActive && mT == 0));
        checkOutput("o_PRI_Internal",  32'(oPriInt), 32'(mActive && pc < mPulseW));
        checkOutput("o_CPI_Internal",  32'(oCpiInt), 32'(mActive));
        checkOutput("o_First_PRI",     32'(oFirst),  32'(mActive && ix == 0));
        checkOutput("o_SRIO_Mem_Sel",  32'(oMem),    32'(mMem));
        checkOutput("o_Waveform_Type", 32'(oWt),     32'(mWt));
        checkOutput("o_CPI_Cnt",       32'(oCnt),    32'(mCnt));
        checkOutput("o_Busy",          32'(oBusy),   32'(mActive || mArm > 0));
        if (mActive) checkOutput("o_PRI_Idx", 32'(oIdx), 32'(ix));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        obsPriP   += int'(oPriP);
        obsCpiP   += int'(oCpiP);
        obsPriInt += int'(oPriInt);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    task automatic applyReset();
        en   = 1'b0;
        rstn = 1'b0;
        stepCycle();
        rstn = 1'b1;
        stepCycle();
    endtask

    task automatic clearCounts();
        obsPriP   = 0;
        obsCpiP   = 0;
        obsPriInt = 0;
    endtask

    initial begin
        bit found;
        int n;

        rstn = 1'b0; en = 1'b0; single = 1'b0;
        priWidth = 16'd130; cpiWidth = 16'd5; pulseWidth = 16'd4; wtype = 3'd2;
        clearCounts();

        // Reset state.
        applyStimulus(3);
        checkOutput("reset_pri_idx", 32'(oIdx), 32'd0);
        rstn = 1'b1;
        applyStimulus(2);

        // Continuous 130/5/4, mid-CPI reconfiguration to 20 clocks and waveform 5, then graceful stop.
        en = 1'b1;
        applyStimulus(2 + 650 * 2 + 300);
        priWidth = 16'd20;
        wtype    = 3'd5;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            stepCycle();
            if (mActive && mPriW == 20 && mT / mPriW == 1) found = 1'b1;
        end
        checkOutput("wait_short_pri_idx1", 32'(found), 32'd1);
        en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            stepCycle();
            if (!oBusy) found = 1'b1;
        end
        checkOutput("stop_reaches_idle", 32'(found), 32'd1);
        checkOutput("cont_cpi_strobes", 32'(obsCpiP), 32'd4);
        checkOutput("cont_pri_strobes", 32'(obsPriP), 32'd20);
        checkOutput("cont_wave_type", 32'(oWt), 32'd5);
        applyStimulus(5);

        // Single-CPI run with enable held high, then a fresh enable rise.
        applyReset();
        priWidth = 16'd10; cpiWidth = 16'd3; pulseWidth = 16'd2; single = 1'b1;
        clearCounts();
        en = 1'b1;
        applyStimulus(60);
        checkOutput("single_pri_strobes", 32'(obsPriP), 32'd3);
        checkOutput("single_cpi_strobes", 32'(obsCpiP), 32'd1);
        checkOutput("single_busy_after", 32'(oBusy), 32'd0);
        checkOutput("single_cpi_cnt", 32'(oCnt), 32'd1);
        en = 1'b0;
        applyStimulus(2);
        en = 1'b1;
        applyStimulus(40);
        checkOutput("single_rearm_cpi_strobes", 32'(obsCpiP), 32'd2);
        checkOutput("single_rearm_cpi_cnt", 32'(oCnt), 32'd2);
        en = 1'b0; single = 1'b0;
        applyStimulus(3);

        // Clamp: PRI=1 runs with a 4-clock period.
        applyReset();
        priWidth = 16'd1; cpiWidth = 16'd2; pulseWidth = 16'd0;
        clearCounts();
        en = 1'b1;
        applyStimulus(18);
        checkOutput("clamp_min_pri_strobes", 32'(obsPriP), 32'd4);
        checkOutput("clamp_min_pri_cpis", 32'(obsCpiP), 32'd2);
        checkOutput("clamp_zero_pulse", 32'(obsPriInt), 32'd0);
        en = 1'b0;
        applyStimulus(4);

        // Clamp: CPI=0 means every PRI is also a CPI start.
        priWidth = 16'd6; cpiWidth = 16'd0; pulseWidth = 16'd2;
        clearCounts();
        en = 1'b1;
        applyStimulus(26);
        checkOutput("clamp_cpi0_pri_strobes", 32'(obsPriP), 32'd4);
        checkOutput("clamp_cpi0_cpi_strobes", 32'(obsCpiP), 32'd4);
        en = 1'b0;
        applyStimulus(4);

        // Clamp: pulse 200 inside a 20-clock PRI stays high for 19 clocks.
        priWidth = 16'd20; cpiWidth = 16'd1; pulseWidth = 16'd200;
        clearCounts();
        en = 1'b1;
        applyStimulus(22);
        checkOutput("clamp_pulse_high_clocks", 32'(obsPriInt), 32'd19);
        en = 1'b0;
        applyStimulus(4);

        // Reset pulse at PRI index 2 aborts the CPI; restart latency measured afterwards.
        applyReset();
        priWidth = 16'd10; cpiWidth = 16'd5; pulseWidth = 16'd3;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            stepCycle();
            if (mActive && mT / mPriW == 2) found = 1'b1;
        end
        checkOutput("wait_pri_idx2", 32'(found), 32'd1);
        rstn = 1'b0;
        stepCycle();
        checkOutput("midrst_cpi_int", 32'(oCpiInt), 32'd0);
        checkOutput("midrst_mem_sel", 32'(oMem), 32'd0);
        checkOutput("midrst_busy", 32'(oBusy), 32'd0);
        checkOutput("midrst_pri_idx", 32'(oIdx), 32'd0);
        rstn = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            stepCycle();
            n++;
            if (oCpiP) found = 1'b1;
        end
        checkOutput("restart_latency", 32'(n - 1), 32'd2);
        applyStimulus(30);
        en = 1'b0;
        applyStimulus(60);

        // Randomized configuration, enable and single-CPI activity.
        for (int r = 0; r < 8; r++) begin
            priWidth   = 16'($urandom_range(1, 24));
            cpiWidth   = 16'($urandom_range(0, 4));
            pulseWidth = 16'($urandom_range(0, 30));
            wtype      = 3'($urandom_range(0, 7));
            single     = ($urandom_range(0, 3) == 0);
            en         = 1'b1;
            for (int c = 0; c < 300; c++) begin
                stepCycle();
                if ($urandom_range(0, 39) == 0) en = !en;
                if ($urandom_range(0, 99) == 0) priWidth = 16'($urandom_range(1, 24));
                if ($urandom_range(0, 99) == 0) pulseWidth = 16'($urandom_range(0, 30));
                if ($urandom_range(0, 99) == 0) wtype = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 149) == 0) single = !single;
            end
            en = 1'b0;
            applyStimulus(200);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
